// File: rtl/gsim_x_drain.sv
// gsim_x_drain: buffers one N_WORDS x IW result burst and replays it as OW-bit
// valid/ready beats; flags short bursts and overlapping bursts. Macro: GSIM_DRAIN_SAT_EN.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid, x_in          : solver result words
//   m_valid, m_ready,
//   m_data, m_last          : output beat handshake
//   frame_done              : pulse after final beat handshake
//   busy                    : not idle
//   err_short, err_ovf      : sticky error flags
//   err_clr                 : synchronous error clear
module gsim_x_drain #(
  parameter int N_WORDS = 16,
  parameter int IW      = 32,
  parameter int OW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [IW-1:0] x_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last,
  output logic          frame_done,
  output logic          busy,
  output logic          err_short,
  output logic          err_ovf,
  input  logic          err_clr
);

  localparam int AW = $clog2(N_WORDS);
  localparam int BW = AW + 1;
`ifdef GSIM_DRAIN_SAT_EN
  localparam int NB = N_WORDS;
`else
  localparam int NB = 2 * N_WORDS;
`endif
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
  localparam logic [BW-1:0] LAST_WR   = BW'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] mem_q [N_WORDS];
  logic [BW-1:0] wr_cnt, wr_cnt_n;
  logic [BW-1:0] rd_beat, rd_beat_n;
  logic [BW-1:0] ld_idx;
  logic          we;
  logic [AW-1:0] wa;
  logic [IW-1:0] word;
  logic [OW-1:0] beat_d;
  logic [OW-1:0] md_n;
  logic          mv_n, ml_n, fd_n, busy_n;
  logic          short_set, ovf_set;

`ifdef GSIM_DRAIN_SAT_EN
  localparam logic [IW:0] HALF = (IW+1)'(1) << (OW - 1);
  localparam logic signed [IW:0] SMAX =
    $signed((IW+1)'((1 << (OW - 1)) - 1));
  localparam logic signed [IW:0] SMIN = ~SMAX;

  logic signed [IW:0] rnd, shr;

  always_comb begin
    word   = mem_q[ld_idx[AW-1:0]];
    rnd    = $signed({word[IW-1], word} + HALF);
    shr    = rnd >>> OW;
    beat_d = shr[OW-1:0];
    if (shr > SMAX)
      beat_d = {1'b0, {(OW-1){1'b1}}};
    else if (shr < SMIN)
      beat_d = {1'b1, {(OW-1){1'b0}}};
  end
`else
  always_comb begin
    word   = mem_q[ld_idx[BW-1:1]];
    beat_d = ld_idx[0] ? word[IW-1:OW]
                       : word[OW-1:0];
  end
`endif

  // The output register holds beat rd_beat; ld_idx is the beat to load
  // next (the current one when empty, the following one on handshake).
  always_comb begin
    state_n   = state;
    wr_cnt_n  = wr_cnt;
    rd_beat_n = rd_beat;
    mv_n      = m_valid;
    md_n      = m_data;
    ml_n      = m_last;
    fd_n      = 1'b0;
    short_set = 1'b0;
    ovf_set   = 1'b0;
    we        = 1'b0;
    wa        = '0;
    ld_idx    = m_valid ? rd_beat + 1'b1 : rd_beat;
    case (state)
      IDLE: begin
        if (in_valid) begin
          we       = 1'b1;
          wr_cnt_n = BW'(1);
          state_n  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          we       = 1'b1;
          wa       = wr_cnt[AW-1:0];
          wr_cnt_n = wr_cnt + 1'b1;
          if (wr_cnt == LAST_WR) begin
            state_n   = DRAIN;
            rd_beat_n = '0;
          end
        end else begin
          short_set = 1'b1;
          wr_cnt_n  = '0;
          state_n   = IDLE;
        end
      end
      DRAIN: begin
        ovf_set = in_valid;
        if (!m_valid) begin
          mv_n = 1'b1;
          md_n = beat_d;
          ml_n = (ld_idx == LAST_BEAT);
        end else if (m_ready) begin
          if (m_last) begin
            mv_n      = 1'b0;
            ml_n      = 1'b0;
            fd_n      = 1'b1;
            wr_cnt_n  = '0;
            rd_beat_n = '0;
            state_n   = IDLE;
          end else begin
            rd_beat_n = ld_idx;
            md_n      = beat_d;
            ml_n      = (ld_idx == LAST_BEAT);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (we)
      mem_q[wa] <= x_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_beat    <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err_short  <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state      <= state_n;
      wr_cnt     <= wr_cnt_n;
      rd_beat    <= rd_beat_n;
      m_valid    <= mv_n;
      m_data     <= md_n;
      m_last     <= ml_n;
      frame_done <= fd_n;
      busy       <= busy_n;
      err_short  <= short_set | (err_short & ~err_clr);
      err_ovf    <= ovf_set | (err_ovf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_gsim_x_drain.sv
// tb_gsim_x_drain: directed bench for gsim_x_drain.
// Frames are driven from tables; beats are checked against a reference model.
module tb_gsim_x_drain;

`ifdef GSIM_DRAIN_SAT_EN
  localparam int B = 16;
`else
  localparam int B = 32;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] x_in;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        frame_done;
  logic        busy;
  logic        err_short;
  logic        err_ovf;
  logic        err_clr;

  int checks = 0;
  int errors = 0;
  int nc;

  logic [31:0] fa [16];
  logic [31:0] fb [16];

  gsim_x_drain #(
    .N_WORDS(16),
    .IW     (32),
    .OW     (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .frame_done(frame_done),
    .busy      (busy),
    .err_short (err_short),
    .err_ovf   (err_ovf),
    .err_clr   (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_beat(input int k);
    logic [31:0] w;
    longint      v;
    if (k < 0 || k >= B) return 16'hDEAD;
`ifdef GSIM_DRAIN_SAT_EN
    w = fa[k];
    v = longint'($signed(w));
    v = (v + 32768) >>> 16;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
`else
    w = fa[k / 2];
    return (k % 2 == 1) ? w[31:16] : w[15:0];
`endif
  endfunction

  task automatic send(input int n, input int sel);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      x_in     = (sel == 0) ? fa[i] : fb[i];
      tick();
    end
    in_valid = 1'b0;
    x_in     = '0;
  endtask

  // pat 0: m_ready held high; pat 1: m_ready repeats 1-0-0-1
  task automatic drain(input int pat, input string tag, output int ncyc);
    int          k;
    int          cyc;
    bit          hold;
    bit          took;
    bit          lastk;
    bit          done;
    logic [15:0] hd;
    logic        hl;
    k    = 0;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 600) begin
      m_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      took  = 0;
      lastk = 0;
      if (m_valid && m_ready) begin
        chk({tag, "_data"}, m_data, exp_beat(k));
        chk({tag, "_last"}, m_last, (k == B - 1));
        took  = 1;
        lastk = m_last;
        k++;
      end
      hold = m_valid && !m_ready;
      hd   = m_data;
      hl   = m_last;
      tick();
      cyc++;
      if (hold) begin
        chk({tag, "_stall_valid"}, m_valid, 1);
        chk({tag, "_stall_data"}, m_data, hd);
        chk({tag, "_stall_last"}, m_last, hl);
      end
      if (took && lastk) begin
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid_off"}, m_valid, 0);
        done = 1;
      end
    end
    ncyc = cyc;
    if (!done) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_beats"}, k, B);
    tick();
    chk({tag, "_done_pulse"}, frame_done, 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    x_in     = '0;
    m_ready  = 1'b0;
    err_clr  = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_short", err_short, 0);
    chk("rst_ovf", err_ovf, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // frame A, sink always ready
    for (int i = 0; i < 16; i++) fa[i] = (i + 1) << 16;
`ifdef GSIM_DRAIN_SAT_EN
    fa[0] = 32'h7FFF8000;
    fa[1] = 32'h80000000;
    fa[2] = 32'h00018000;
    fa[3] = 32'hFFFF7FFF;
`endif
    m_ready = 1'b1;
    send(16, 0);
    chk("a_lat_n", m_valid, 0);
    chk("a_busy", busy, 1);
    tick();
    chk("a_lat_n1", m_valid, 1);
`ifdef GSIM_DRAIN_SAT_EN
    chk("a_beat0", m_data, 16'h7FFF);
`else
    chk("a_beat0", m_data, 16'h0000);
`endif
    drain(0, "a", nc);
    chk("a_cycles", nc, B);

    // frame B, sink toggles 1-0-0-1
    for (int i = 0; i < 16; i++)
      fa[i] = 32'hA5C3_0F81 ^ (i * 32'h0111_1011);
    send(16, 0);
    drain(1, "b", nc);

    // short burst then clear
    send(9, 0);
    chk("s_busy", busy, 1);
    tick();
    chk("s_err", err_short, 1);
    chk("s_busy_off", busy, 0);
    chk("s_valid", m_valid, 0);
    repeat (3) tick();
    chk("s_valid_late", m_valid, 0);
    chk("s_ovf", err_ovf, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("s_clr", err_short, 0);

    // overlapping burst during stalled drain; set beats clear
    for (int i = 0; i < 16; i++) begin
      fa[i] = 32'h1357_0000 + i * 32'h0003_0005;
      fb[i] = 32'hFFFF_FFFF - i;
    end
    m_ready = 1'b0;
    send(16, 0);
    err_clr = 1'b1;
    send(16, 1);
    err_clr = 1'b0;
    chk("o_err", err_ovf, 1);
    chk("o_busy", busy, 1);
    chk("o_valid", m_valid, 1);
    chk("o_beat0", m_data, exp_beat(0));
    drain(0, "o", nc);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("o_clr", err_ovf, 0);

    // reset mid-drain at beat 5
    for (int i = 0; i < 16; i++) fa[i] = 32'h2468_ACE0 + i * 32'h1000_0001;
    m_ready = 1'b1;
    send(16, 0);
    tick();
    repeat (5) tick();
    chk("r_beat5", m_data, exp_beat(5));
    m_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("r_valid", m_valid, 0);
    chk("r_busy", busy, 0);
    chk("r_data", m_data, 0);
    chk("r_short", err_short, 0);
    #1 reset = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) fa[i] = 32'h8000_7FFF ^ (i << 20);
    send(16, 0);
    drain(0, "e", nc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
